// File: rtl/radix4_bfly_fft4.sv
// radix4_bfly_fft4: two-stage pipelined radix-4 DIT butterfly with group-order and frame tracking.
// Build option: define FFT4_BFLY_SCALE_EN to divide stage-2 results by 4 with round-half-up.
module radix4_bfly_fft4 #(
  parameter int IN_WIDTH  = 27,
  parameter int GROUPS    = 2048,
  parameter int IDX_WIDTH = 11,
  localparam int OUT_WIDTH = IN_WIDTH + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid,
  input  logic        [IDX_WIDTH-1:0] index,
  input  logic signed [IN_WIDTH-1:0]  x0_r,
  input  logic signed [IN_WIDTH-1:0]  x0_i,
  input  logic signed [IN_WIDTH-1:0]  x1_r,
  input  logic signed [IN_WIDTH-1:0]  x1_i,
  input  logic signed [IN_WIDTH-1:0]  x2_r,
  input  logic signed [IN_WIDTH-1:0]  x2_i,
  input  logic signed [IN_WIDTH-1:0]  x3_r,
  input  logic signed [IN_WIDTH-1:0]  x3_i,
  output logic signed [OUT_WIDTH-1:0] y0_r,
  output logic signed [OUT_WIDTH-1:0] y0_i,
  output logic signed [OUT_WIDTH-1:0] y1_r,
  output logic signed [OUT_WIDTH-1:0] y1_i,
  output logic signed [OUT_WIDTH-1:0] y2_r,
  output logic signed [OUT_WIDTH-1:0] y2_i,
  output logic signed [OUT_WIDTH-1:0] y3_r,
  output logic signed [OUT_WIDTH-1:0] y3_i,
  output logic        [IDX_WIDTH-1:0] index_out,
  output logic                        ready,
  output logic                        frame_done,
  output logic                        seq_err
);

  localparam int S1W = IN_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GROUPS - 1);

  logic signed [S1W-1:0] aR_d, aI_d, bR_d, bI_d, cR_d, cI_d, dR_d, dI_d;
  logic signed [S1W-1:0] aR_q, aI_q, bR_q, bI_q, cR_q, cI_q, dR_q, dI_q;

  logic signed [OUT_WIDTH-1:0] y0R_d, y0I_d, y1R_d, y1I_d, y2R_d, y2I_d, y3R_d, y3I_d;
  logic signed [OUT_WIDTH-1:0] y0R_q, y0I_q, y1R_q, y1I_q, y2R_q, y2I_q, y3R_q, y3I_q;

  logic                 v1_d, v1_q, v2_d, v2_q;
  logic [IDX_WIDTH-1:0] idx1_d, idx1_q, idx2_d, idx2_q;
  logic                 fd_d, fd_q;
  logic [IDX_WIDTH-1:0] expIdx_d, expIdx_q;
  logic                 seqErr_d, seqErr_q;

`ifdef FFT4_BFLY_SCALE_EN
  localparam logic signed [OUT_WIDTH:0] RND = (OUT_WIDTH+1)'(2);
`endif

  // Final output conditioning: optional divide-by-4 with round-half-up.
  function automatic logic signed [OUT_WIDTH-1:0] outScale(input logic signed [OUT_WIDTH-1:0] v);
`ifdef FFT4_BFLY_SCALE_EN
    logic signed [OUT_WIDTH:0] t;
    t = $signed({v[OUT_WIDTH-1], v}) + RND;
    return {t[OUT_WIDTH], t[OUT_WIDTH:2]};
`else
    return v;
`endif
  endfunction

  always_comb begin
    aR_d = S1W'(x0_r) + S1W'(x2_r);
    aI_d = S1W'(x0_i) + S1W'(x2_i);
    bR_d = S1W'(x0_r) - S1W'(x2_r);
    bI_d = S1W'(x0_i) - S1W'(x2_i);
    cR_d = S1W'(x1_r) + S1W'(x3_r);
    cI_d = S1W'(x1_i) + S1W'(x3_i);
    dR_d = S1W'(x1_r) - S1W'(x3_r);
    dI_d = S1W'(x1_i) - S1W'(x3_i);
  end

  // y1 = b - j*d and y3 = b + j*d swap the real/imag parts of d.
  always_comb begin
    y0R_d = outScale(OUT_WIDTH'(aR_q) + OUT_WIDTH'(cR_q));
    y0I_d = outScale(OUT_WIDTH'(aI_q) + OUT_WIDTH'(cI_q));
    y2R_d = outScale(OUT_WIDTH'(aR_q) - OUT_WIDTH'(cR_q));
    y2I_d = outScale(OUT_WIDTH'(aI_q) - OUT_WIDTH'(cI_q));
    y1R_d = outScale(OUT_WIDTH'(bR_q) + OUT_WIDTH'(dI_q));
    y1I_d = outScale(OUT_WIDTH'(bI_q) - OUT_WIDTH'(dR_q));
    y3R_d = outScale(OUT_WIDTH'(bR_q) - OUT_WIDTH'(dI_q));
    y3I_d = outScale(OUT_WIDTH'(bI_q) + OUT_WIDTH'(dR_q));
  end

  // Expected index resynchronises to whatever arrived, so one skip flags once.
  always_comb begin
    expIdx_d = expIdx_q;
    seqErr_d = seqErr_q;
    if (valid) begin
      if (index != expIdx_q) begin
        seqErr_d = 1'b1;
      end
      expIdx_d = (index == LAST_IDX) ? '0 : index + 1'b1;
    end
  end

  always_comb begin
    v1_d   = valid;
    v2_d   = v1_q;
    idx1_d = valid ? index : idx1_q;
    idx2_d = v1_q ? idx1_q : idx2_q;
    fd_d   = v1_q && (idx1_q == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aR_q <= '0; aI_q <= '0; bR_q <= '0; bI_q <= '0;
      cR_q <= '0; cI_q <= '0; dR_q <= '0; dI_q <= '0;
    end else begin
      aR_q <= aR_d; aI_q <= aI_d; bR_q <= bR_d; bI_q <= bI_d;
      cR_q <= cR_d; cI_q <= cI_d; dR_q <= dR_d; dI_q <= dI_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0R_q <= '0; y0I_q <= '0; y1R_q <= '0; y1I_q <= '0;
      y2R_q <= '0; y2I_q <= '0; y3R_q <= '0; y3I_q <= '0;
    end else begin
      y0R_q <= y0R_d; y0I_q <= y0I_d; y1R_q <= y1R_d; y1I_q <= y1I_d;
      y2R_q <= y2R_d; y2I_q <= y2I_d; y3R_q <= y3R_d; y3I_q <= y3I_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      fd_q     <= 1'b0;
      expIdx_q <= '0;
      seqErr_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      idx1_q   <= idx1_d;
      idx2_q   <= idx2_d;
      fd_q     <= fd_d;
      expIdx_q <= expIdx_d;
      seqErr_q <= seqErr_d;
    end
  end

  assign y0_r       = y0R_q;
  assign y0_i       = y0I_q;
  assign y1_r       = y1R_q;
  assign y1_i       = y1I_q;
  assign y2_r       = y2R_q;
  assign y2_i       = y2I_q;
  assign y3_r       = y3R_q;
  assign y3_i       = y3I_q;
  assign index_out  = idx2_q;
  assign ready      = v2_q;
  assign frame_done = fd_q;
  assign seq_err    = seqErr_q;

endmodule

// File: tb/tb_radix4_bfly_fft4.sv
// tb_radix4_bfly_fft4: random and directed groups against a direct 4-point DFT model,
// with a queue scoreboard checked by an independent output monitor.
module tb_radix4_bfly_fft4;
  localparam int IN_W   = 27;
  localparam int OUT_W  = IN_W + 2;
  localparam int GROUPS = 2048;
  localparam int IDX_W  = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic [IDX_W-1:0] index = '0;
  logic signed [IN_W-1:0] x0_r = '0, x0_i = '0, x1_r = '0, x1_i = '0;
  logic signed [IN_W-1:0] x2_r = '0, x2_i = '0, x3_r = '0, x3_i = '0;
  logic signed [OUT_W-1:0] y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i;
  logic [IDX_W-1:0] index_out;
  logic ready, frame_done, seq_err;

  radix4_bfly_fft4 dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .index(index),
    .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i),
    .x2_r(x2_r), .x2_i(x2_i), .x3_r(x3_r), .x3_i(x3_i),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
    .y2_r(y2_r), .y2_i(y2_i), .y3_r(y3_r), .y3_i(y3_i),
    .index_out(index_out), .ready(ready), .frame_done(frame_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checkCount = 0;
  int passCount  = 0;
  int readyCount = 0;
  int fdCount    = 0;

  int xr[4], xi[4];
  int modR[4], modI[4];
  int dirR[4], dirI[4];

  int     expR[$], expI[$], expIdxQ[$];
  longint dueQ[$];

  int gotR[4], gotI[4];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Reference: y_k = sum_n x_n * (-j)^(n*k), evaluated by quarter-turn rotations.
  task automatic computeModel();
    int accR, accI;
    for (int k = 0; k < 4; k++) begin
      accR = 0;
      accI = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0:       begin accR += xr[n]; accI += xi[n]; end
          1:       begin accR += xi[n]; accI -= xr[n]; end
          2:       begin accR -= xr[n]; accI -= xi[n]; end
          default: begin accR -= xi[n]; accI += xr[n]; end
        endcase
      end
`ifdef FFT4_BFLY_SCALE_EN
      accR = (accR + 2) >>> 2;
      accI = (accI + 2) >>> 2;
`endif
      modR[k] = accR;
      modI[k] = accI;
    end
  endtask

  task automatic randomData();
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
      xi[n] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    end
  endtask

  task automatic driveBus();
    x0_r = IN_W'(xr[0]); x0_i = IN_W'(xi[0]);
    x1_r = IN_W'(xr[1]); x1_i = IN_W'(xi[1]);
    x2_r = IN_W'(xr[2]); x2_i = IN_W'(xi[2]);
    x3_r = IN_W'(xr[3]); x3_i = IN_W'(xi[3]);
  endtask

  // Drive one group for the next edge and push its expected response.
  task automatic applyStimulus(input int idx, input bit directed);
    @(posedge clk);
    #1;
    valid = 1'b1;
    index = IDX_W'(idx);
    driveBus();
    computeModel();
    for (int k = 0; k < 4; k++) begin
      expR.push_back(directed ? dirR[k] : modR[k]);
      expI.push_back(directed ? dirI[k] : modI[k]);
    end
    expIdxQ.push_back(idx);
    dueQ.push_back(cyc + 2);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    valid = 1'b0;
    index = IDX_W'($urandom);
    randomData();
    driveBus();
  endtask

  task automatic flushScoreboard();
    expR.delete();
    expI.delete();
    expIdxQ.delete();
    dueQ.delete();
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    flushScoreboard();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic runFrame(input bit withGaps);
    int r0, f0;
    r0 = readyCount;
    f0 = fdCount;
    for (int g = 0; g < GROUPS; g++) begin
      if (withGaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) idleCycle();
      end
      randomData();
      applyStimulus(g, 1'b0);
    end
    repeat (4) idleCycle();
    @(negedge clk);
    checkOutput(withGaps ? "gapFrameReadyCount" : "frameReadyCount", readyCount - r0, GROUPS);
    checkOutput(withGaps ? "gapFrameDoneCount" : "frameDoneCount", fdCount - f0, 1);
    checkOutput(withGaps ? "gapFrameSeqErr" : "frameSeqErr", seq_err, 0);
  endtask

  // Monitor: zero outputs under reset, scoreboard pops on ready, nothing missing or spurious.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("resetReady", ready, 0);
      checkOutput("resetFrameDone", frame_done, 0);
      checkOutput("resetSeqErr", seq_err, 0);
      checkOutput("resetIndexOut", index_out, 0);
      checkOutput("resetData", |{y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i}, 0);
    end else if (ready) begin
      readyCount++;
      if (frame_done) fdCount++;
      if (dueQ.size() == 0) begin
        checkOutput("spuriousReady", 1, 0);
      end else begin
        gotR = '{y0_r, y1_r, y2_r, y3_r};
        gotI = '{y0_i, y1_i, y2_i, y3_i};
        checkOutput("latency", cyc, dueQ.pop_front());
        checkOutput("indexOut", index_out, expIdxQ[0]);
        checkOutput("frameDone", frame_done, (expIdxQ[0] == GROUPS - 1) ? 1 : 0);
        void'(expIdxQ.pop_front());
        for (int k = 0; k < 4; k++) begin
          checkOutput($sformatf("y%0d_r", k), gotR[k], expR.pop_front());
          checkOutput($sformatf("y%0d_i", k), gotI[k], expI.pop_front());
        end
      end
    end else begin
      checkOutput("idleFrameDone", frame_done, 0);
      if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
        checkOutput("missingReady", 0, 1);
        void'(dueQ.pop_front());
        void'(expIdxQ.pop_front());
        for (int k = 0; k < 4; k++) begin
          void'(expR.pop_front());
          void'(expI.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef FFT4_BFLY_SCALE_EN
    xr = '{5, 0, 0, 0};     xi = '{-5, 0, 0, 0};
    dirR = '{1, 1, 1, 1};   dirI = '{-1, -1, -1, -1};
    applyStimulus(0, 1'b1);
    xr = '{100, 0, 0, 0};   xi = '{0, 0, 0, 0};
    applyStimulus(1, 1'b0);
    xr = '{0, 0, 0, 0};     xi = '{0, 100, 0, 0};
    applyStimulus(2, 1'b0);
    xr = '{-(1 << 26), -(1 << 26), -(1 << 26), -(1 << 26)}; xi = '{0, 0, 0, 0};
    applyStimulus(3, 1'b0);
`else
    xr = '{100, 0, 0, 0};   xi = '{0, 0, 0, 0};
    dirR = '{100, 100, 100, 100}; dirI = '{0, 0, 0, 0};
    applyStimulus(0, 1'b1);
    xr = '{0, 0, 0, 0};     xi = '{0, 100, 0, 0};
    dirR = '{0, 100, 0, -100};    dirI = '{100, 0, -100, 0};
    applyStimulus(1, 1'b1);
    xr = '{(1 << 26) - 1, (1 << 26) - 1, (1 << 26) - 1, (1 << 26) - 1}; xi = '{0, 0, 0, 0};
    dirR = '{268435452, 0, 0, 0}; dirI = '{0, 0, 0, 0};
    applyStimulus(2, 1'b1);
    xr = '{-(1 << 26), -(1 << 26), -(1 << 26), -(1 << 26)};
    dirR = '{-268435456, 0, 0, 0};
    applyStimulus(3, 1'b1);
`endif
    repeat (4) idleCycle();
    @(negedge clk);
    checkOutput("directedSeqErr", seq_err, 0);
    applyReset();

    runFrame(1'b0);
    runFrame(1'b1);

    randomData(); applyStimulus(0, 1'b0);
    randomData(); applyStimulus(1, 1'b0);
    idleCycle();
    @(negedge clk);
    checkOutput("seqErrBeforeSkip", seq_err, 0);
    randomData(); applyStimulus(3, 1'b0);
    idleCycle();
    @(negedge clk);
    checkOutput("seqErrAfterSkip", seq_err, 1);
    repeat (3) idleCycle();
    @(negedge clk);
    checkOutput("seqErrSticky", seq_err, 1);

    randomData(); applyStimulus(4, 1'b0);
    randomData(); applyStimulus(5, 1'b0);
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    flushScoreboard();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = readyCount;
    repeat (3) idleCycle();
    @(negedge clk);
    checkOutput("noReadyAfterReset", readyCount - r0, 0);
    checkOutput("seqErrAfterReset", seq_err, 0);

    for (int g = 0; g < 16; g++) begin
      randomData();
      applyStimulus(g, 1'b0);
    end
    repeat (4) idleCycle();
    @(negedge clk);
    checkOutput("restartReadyCount", readyCount - r0, 16);
    checkOutput("restartSeqErr", seq_err, 0);
    checkOutput("scoreboardDrained", dueQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
